// File: rtl/loop_nest_counter.sv
// Chain of carry-linked loop counters driving the convolution loop nest.
// Level 0 is innermost; each level counts 0..goal and carries outward on wrap.
module loop_nest_counter #(
    parameter int W      = 8,
    parameter int LEVELS = 4,
    parameter int IW     = 16,
    parameter int WRAP   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                init0,
    input  logic                cen,
    input  logic [LEVELS*W-1:0] goal,
    output logic [LEVELS*W-1:0] cnt,
    output logic [LEVELS-1:0]   co,
    output logic                last,
    output logic [IW-1:0]       idx,
    output logic                done
);

    logic [LEVELS-1:0] at;
    logic [LEVELS-1:0] adv;
    logic              hold;
    logic              adv0;
    logic [IW-1:0]     idx_reg;
    logic              done_reg;

    assign last = &at;
    assign hold = (WRAP == 0) && last;
    assign adv0 = cen & ~init0 & ~hold;

    genvar gi;
    generate
        for (gi = 0; gi < LEVELS; gi = gi + 1) begin : g_level
            logic [W-1:0] cnt_reg;

            assign at[gi] = (cnt_reg == goal[gi*W +: W]);

            // A level advances only when every inner level sits at its goal.
            if (gi == 0) begin : g_inner
                assign adv[gi] = adv0;
            end else begin : g_outer
                assign adv[gi] = adv0 & (&at[gi-1:0]);
            end

            assign co[gi] = adv[gi] & at[gi];
            assign cnt[gi*W +: W] = cnt_reg;

            always_ff @(posedge clk) begin
                if (rst || init0) begin
                    cnt_reg <= '0;
                end else if (adv[gi]) begin
                    cnt_reg <= at[gi] ? '0 : cnt_reg + W'(1);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || init0) begin
            idx_reg <= '0;
        end else if (adv0) begin
            idx_reg <= ((WRAP != 0) && last) ? '0 : idx_reg + IW'(1);
        end
    end

    generate
        if (WRAP != 0) begin : g_done_wrap
            // One-cycle pulse marking the wrap back to all-zero.
            always_ff @(posedge clk) begin
                if (rst || init0) begin
                    done_reg <= 1'b0;
                end else begin
                    done_reg <= adv0 & last;
                end
            end
        end else begin : g_done_hold
            // Sticky once a request arrives while parked on the last state.
            always_ff @(posedge clk) begin
                if (rst || init0) begin
                    done_reg <= 1'b0;
                end else if (cen && last) begin
                    done_reg <= 1'b1;
                end
            end
        end
    endgenerate

    assign idx  = idx_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_loop_nest_counter.sv
// Directed bench for loop_nest_counter: one wrapping and one holding instance
// checked each cycle against a mixed-radix position model.
module tb_loop_nest_counter;

    localparam int W  = 4;
    localparam int L  = 3;
    localparam int IW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, init_w, cen_w, init_h, cen_h;
    logic [L*W-1:0] goal;
    logic [L*W-1:0] cnt_w, cnt_h;
    logic [L-1:0]   co_w, co_h;
    logic           last_w, last_h;
    logic [IW-1:0]  idx_w, idx_h;
    logic           done_w, done_h;

    int   g [L];
    int   err_cnt = 0;
    int   chk_cnt = 0;
    int   mw_pos  = 0;
    int   mh_pos  = 0;
    logic mw_done = 1'b0;
    logic mh_done = 1'b0;

    loop_nest_counter #(.W(W), .LEVELS(L), .IW(IW), .WRAP(1)) dut_w (
        .clk(clk), .rst(rst), .init0(init_w), .cen(cen_w), .goal(goal),
        .cnt(cnt_w), .co(co_w), .last(last_w), .idx(idx_w), .done(done_w)
    );

    loop_nest_counter #(.W(W), .LEVELS(L), .IW(IW), .WRAP(0)) dut_h (
        .clk(clk), .rst(rst), .init0(init_h), .cen(cen_h), .goal(goal),
        .cnt(cnt_h), .co(co_h), .last(last_h), .idx(idx_h), .done(done_h)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int span(input int i);
        int p = 1;
        for (int j = 0; j <= i; j++) p = p * (g[j] + 1);
        return p;
    endfunction

    function automatic logic [L*W-1:0] digits(input int pos);
        logic [L*W-1:0] r = '0;
        for (int i = 0; i < L; i++) r[i*W +: W] = W'((pos / span(i-1)) % (g[i] + 1));
        return r;
    endfunction

    function automatic logic [L-1:0] exp_co(input int pos, input logic a);
        logic [L-1:0] r = '0;
        for (int i = 0; i < L; i++) r[i] = a && (((pos + 1) % span(i)) == 0);
        return r;
    endfunction

    task automatic set_goals(input int a, input int b, input int c);
        g[0] = a; g[1] = b; g[2] = c;
        goal = {W'(c), W'(b), W'(a)};
    endtask

    // Drive one cycle, check both instances, advance the models.
    task automatic cyc(input logic r, input logic iw, input logic cw, input logic ih, input logic ch);
        int   t;
        logic lw, lh, acc_h;
        @(negedge clk);
        rst = r; init_w = iw; cen_w = cw; init_h = ih; cen_h = ch;
        #1;
        t  = span(L-1);
        lw = (mw_pos == t - 1);
        lh = (mh_pos == t - 1);
        acc_h = ch & ~ih & ~lh;

        chk("w_cnt",  32'(cnt_w),  32'(digits(mw_pos)));
        chk("w_idx",  32'(idx_w),  32'(mw_pos));
        chk("w_last", 32'(last_w), 32'(lw));
        chk("w_co",   32'(co_w),   32'(exp_co(mw_pos, cw & ~iw)));
        chk("w_done", 32'(done_w), 32'(mw_done));
        chk("h_cnt",  32'(cnt_h),  32'(digits(mh_pos)));
        chk("h_idx",  32'(idx_h),  32'(mh_pos));
        chk("h_last", 32'(last_h), 32'(lh));
        chk("h_co",   32'(co_h),   32'(exp_co(mh_pos, acc_h)));
        chk("h_done", 32'(done_h), 32'(mh_done));

        $display("t=%0t rst=%b | w: init=%b cen=%b cnt=%h co=%b last=%b idx=%0d done=%b | h: init=%b cen=%b cnt=%h co=%b last=%b idx=%0d done=%b",
                 $time, r, iw, cw, cnt_w, co_w, last_w, idx_w, done_w,
                 ih, ch, cnt_h, co_h, last_h, idx_h, done_h);

        if (r || iw) begin
            mw_pos = 0; mw_done = 1'b0;
        end else begin
            mw_done = cw & lw;
            if (cw) mw_pos = (mw_pos + 1) % t;
        end
        if (r || ih) begin
            mh_pos = 0; mh_done = 1'b0;
        end else begin
            if (ch && lh) mh_done = 1'b1;
            if (acc_h) mh_pos = mh_pos + 1;
        end
        @(posedge clk);
    endtask

    initial begin
        rst = 1'b1; init_w = 1'b0; cen_w = 1'b0; init_h = 1'b0; cen_h = 1'b0;
        set_goals(3, 1, 2);
        repeat (2) @(posedge clk);

        // Reset state, then reset mid-count with cen held.
        cyc(1, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) cyc(0, 0, 1, 0, 1);
        cyc(1, 0, 1, 0, 1);
        cyc(1, 0, 1, 0, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        // Full sweep on both instances; the holding one gets 30 requests.
        for (int k = 1; k <= 30; k++) cyc(0, 0, (k <= 24), 0, 1);
        #1;
        chk("sweep_w_cnt",  32'(cnt_w),  32'h0);
        chk("sweep_h_cnt",  32'(cnt_h),  32'h213);
        chk("sweep_h_idx",  32'(idx_h),  32'd23);
        chk("sweep_h_done", 32'(done_h), 32'd1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 1, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        // init0 beats cen at cnt {2,1,0}.
        for (int k = 0; k < 6; k++) cyc(0, 0, 1, 0, 1);
        #1;
        chk("prio_w_cnt", 32'(cnt_w), 32'h012);
        chk("prio_h_cnt", 32'(cnt_h), 32'h012);
        cyc(0, 1, 1, 1, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        // Random gaps with a zero goal and a full-modulus goal.
        cyc(1, 0, 0, 0, 0);
        set_goals(15, 0, 3);
        for (int k = 0; k < 1000; k++) begin
            logic c;
            c = 1'($urandom_range(0, 1));
            cyc(0, 0, c, 0, c);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/loop_nest_counter.md
# loop_nest_counter

Parametrised chain of carry-linked counters that sequences the nested loops of the convolution datapath (kernel column, kernel row, output column, output row, ...). Each level counts 0..goal inclusive and carries into the next level on wrap. A running linear index tracks position in the sweep. A selectable end-of-sweep mode either wraps the nest or holds it with a sticky done flag. It replaces the single-level counters in the controller, so one instance drives all loop indices and the 1-multiplier MAC schedule.

## Interface
- W, default 8: width of each level counter and its goal.
- LEVELS, default 4: number of nested levels; level 0 is innermost.
- IW, default 16: width of the linear index output.
- WRAP, default 1: 1 means the nest wraps to all-zero after the last state; 0 means the nest holds at the last state.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- init0  in  1  synchronous clear of all levels, index and done.
- cen  in  1  advance request for the innermost level.
- goal  in  LEVELS*W  per-level terminal values; level i occupies bits [i*W +: W].
- cnt  out  LEVELS*W  per-level counts, same packing as goal.
- co  out  LEVELS  combinational per-level carry-out, high when level i wraps this cycle.
- last  out  1  combinational; high when every level equals its goal.
- idx  out  IW  number of accepted advances since the last clear.
- done  out  1  registered end-of-sweep flag.

## Operation
- Definitions, all combinational:
  - at[i] = (cnt[i] == goal[i]).
  - last = AND of all at[i].
  - hold = (WRAP==0) & last.
  - adv[0] = cen & ~init0 & ~hold.
  - adv[i] = adv[i-1] & at[i-1] for i > 0.
  - co[i] = adv[i] & at[i].
- Level update on a clock edge, in priority order:
  - rst or init0: cnt[i] <= 0.
  - adv[i] & at[i]: cnt[i] <= 0.
  - adv[i]: cnt[i] <= cnt[i]+1.
  - Otherwise cnt[i] holds.
- A level with goal = 0 stays at 0 and passes every advance through as a carry.
- goal = 2^W-1 gives the full modulus.
- Goals are sampled live every cycle.
  - Changing a goal mid-sweep to a value below the current count makes that level run up to 2^W-1, wrap through 0, and continue.
  - The controller shall only change goals while init0 is asserted.
- idx:
  - Cleared by rst or init0.
  - Incremented modulo 2^IW on each adv[0].
  - Also cleared on a full-nest wrap when WRAP=1.
- done, WRAP=1:
  - Set for exactly one cycle, the cycle after adv[0] & last, i.e. the wrap to all-zero.
  - Deasserted otherwise.
- done, WRAP=0:
  - Set on the edge where cen & last & ~init0.
  - Sticky until rst or init0.
  - While last, cen has no effect: no counter or idx change, and co = 0.
- Simultaneous init0 and cen: init0 wins, nothing advances, co = 0.

## Timing
- Reset values, one edge after rst high: cnt = 0, idx = 0, done = 0.
  - co and last then follow from cnt and goal combinationally, so last = 1 only if all goals are 0.
- Latency:
  - cnt and idx update on the same edge that samples cen.
  - co and last are valid in the same cycle as the cnt/cen they depend on.
  - done follows one edge after the terminal advance.
- Full sweep length is the product of (goal[i]+1) advances.
- Reset mid-sweep aborts on the next edge with no done pulse.
- cen may be held continuously; every cycle with cen high and no hold is one advance, with no bubbles at carries.

## Test plan
- Reset/init
  - Stimulus: LEVELS=3, W=4, goals {0:3, 1:1, 2:2}; assert rst for 2 cycles mid-count.
  - Required: cnt = 0, idx = 0, done = 0 after the edge; no done pulse.
- Full sweep, WRAP=1
  - Stimulus: same goals, cen held for 24 cycles.
  - Required: co[0] on cycles 4, 8, ...; co[1] on cycles 8, 16, 24; co[2] only on cycle 24.
  - Required: last high during cycle 24; cnt = 0 and idx = 0 afterwards; done high for exactly cycle 25.
- Hold mode, WRAP=0
  - Stimulus: same goals, cen for 30 cycles.
  - Required: cnt freezes at {3,1,2} and idx = 23 from cycle 24 on; done rises after cycle 24 and stays high; co = 0 while holding.
  - Stimulus: then pulse init0.
  - Required: all outputs cleared.
- Priority
  - Stimulus: init0 and cen high together at cnt {2,1,0}.
  - Required: cnt = 0 next cycle, co = 0 that cycle.
- Gaps and boundary goals
  - Stimulus: cen toggled randomly; goal[1] = 0 and goal[0] = 15.
  - Required: level 0 counts to 15 with stalls honoured; level 1 stays at 0 and co[1] = co[0].
  - Stimulus: compare against a scoreboard over 1000 cycles.
  - Required: idx equals the accepted-advance count.
